tlul_source_remap: RTL and testbench
====================================

# tlul_source_remap

Parametrised TL-UL source-ID remapper between a RocketChip-side host port with a wide `a_source` and an OpenTitan-side device port limited to `top_pkg::TL_AIW` source bits. It allocates a free narrow ID per accepted A beat and records the original host source in a table. On the matching D response it restores the host source and releases the ID. Only source fields and valid/ready pass through this block; all other A/D payload fields are routed around it by the enclosing adapter.

## Interface
Parameters:
- `HostSrcW`, 8: width of host-side `a_source`/`d_source`.
- `NumIds`, 16: narrow IDs available; must satisfy 1 ≤ NumIds ≤ 2^TL_AIW.
- `CntW`, $clog2(NumIds+1): width of the outstanding and high-water-mark counters.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `host_a_valid_i`  in  1  host A valid.
- `host_a_ready_o`  out  1  host A ready.
- `host_a_source_i`  in  HostSrcW  host A source.
- `dev_a_valid_o`  out  1  device A valid.
- `dev_a_ready_i`  in  1  device A ready.
- `dev_a_source_o`  out  TL_AIW  allocated narrow ID.
- `dev_d_valid_i`  in  1  device D valid.
- `dev_d_ready_o`  out  1  device D ready.
- `dev_d_source_i`  in  TL_AIW  narrow ID of the response.
- `host_d_valid_o`  out  1  host D valid.
- `host_d_ready_i`  in  1  host D ready.
- `host_d_source_o`  out  HostSrcW  restored host source.
- `full_o`  out  1  no free ID.
- `err_o`  out  1  sticky: D response for an ID that is not in use, or with an ID ≥ NumIds.
- `outstanding_o`  out  CntW  IDs currently in use.
- `hwm_o`  out  CntW  high-water mark of `outstanding_o`.

## Operation
- State:
  - `busy_q[NumIds]`: one bit per ID.
  - `tbl_q[NumIds][HostSrcW]`: stored host source per ID.
  - `err_q`.
  - Stats counters.
- Allocation:
  - `free_idx` = lowest index with `busy_q` = 0.
  - `any_free` = |~busy_q.
  - `dev_a_valid_o` = host_a_valid_i & any_free.
  - `host_a_ready_o` = dev_a_ready_i & any_free.
  - `dev_a_source_o` = free_idx, zero-extended to TL_AIW.
- A handshake (dev_a_valid_o & dev_a_ready_i): `busy_q[free_idx]` ← 1 and `tbl_q[free_idx]` ← host_a_source_i.
- Response path:
  - `host_d_valid_o` = dev_d_valid_i.
  - `dev_d_ready_o` = host_d_ready_i.
  - `host_d_source_o` = tbl_q[dev_d_source_i]. When the ID is ≥ NumIds, this output is 0.
- D handshake: `busy_q[dev_d_source_i]` ← 0. If that bit was already 0, or the ID is ≥ NumIds, `err_q` ← 1 and `busy_q` is left unchanged.
- Simultaneous A and D handshakes in the same cycle:
  - Both updates apply.
  - Allocation always uses the registered `busy_q`, so an ID freed this cycle becomes reusable next cycle.
  - Same-index conflict cannot occur, because the allocated index is free and the freed index is busy.
- Full: with all IDs busy, `host_a_ready_o` = 0 and `dev_a_valid_o` = 0. The D path is unaffected.
- `full_o` = ~any_free, combinational from registered state.
- `err_o` is cleared only by reset.

## Timing
- Zero-cycle latency on both channels; all paths from input to output are combinational.
- Each handshake updates state on the next rising edge of `clk_i`.
- Reset values: `busy_q` = 0, `tbl_q` = 0, `err_q` = 0, counters = 0.
- Output values under reset: `full_o` = 0, `err_o` = 0, `outstanding_o` = 0, `hwm_o` = 0, `host_a_ready_o` = dev_a_ready_i, `dev_a_source_o` = 0.
- Reset asserted mid-transaction discards all outstanding IDs. D responses that arrive after reset release set `err_o`.
- Ready never depends on valid of the same channel. This preserves TL-UL no-combinational-loop rules.

## Configuration
- `CEP_TLUL_REMAP_STATS_EN` defined:
  - `outstanding_o` tracks popcount(busy_q). It is +1 on A handshake, −1 on a valid D release, and unchanged when both occur in one cycle.
  - `hwm_o` ← max(hwm_o, next outstanding) every cycle.
- `CEP_TLUL_REMAP_STATS_EN` undefined: no counter registers are built, and `outstanding_o` and `hwm_o` are tied to 0.

## Structure
- `TL_AIW` comes from `top_pkg`.
- A new constant `TL_HOST_AIW_MAX` = 16 (upper bound for HostSrcW) is added to `top_pkg`.
- Sub-module `tlul_remap_alloc`: lowest-free priority encoder producing `free_idx` and `any_free` from `busy_q`, parametrised by NumIds.

## Test plan
- Reset, then 16 back-to-back A beats with sources 0x80..0x8F and dev_a_ready_i = 1 → dev sources 0..15, `full_o` = 1 after the 16th beat, 17th beat stalled with host_a_ready_o = 0, `outstanding_o` = 16.
- Full state, then D on ID 5 → host_d_source_o = 0x85. Next cycle the stalled A beat is accepted with dev source 5.
- Same-cycle A accept and D release of ID 3 with 15 busy → A gets the lowest free ID (not 3), ID 3 is free the next cycle, `outstanding_o` is unchanged.
- D response on idle ID 7 → `err_o` = 1 and stays 1. D with source 15 when NumIds = 8 → `err_o` = 1 and host_d_source_o = 0.
- Host stalls D (host_d_ready_i = 0) for 4 cycles → dev_d_ready_o = 0 and the ID stays busy until the handshake.
- Reset asserted with 6 outstanding → all outputs return to reset values. With stats on, `hwm_o` held 6 before reset and reads 0 after.

Source files
------------

// File: rtl/top_pkg.sv
// Shared TL-UL sizing constants for the OpenTitan-side fabric.
//   TL_AIW          : width of the device-side a_source/d_source fields.
//   TL_HOST_AIW_MAX : largest host-side source width that remappers
//                     in front of this fabric are expected to accept.
package top_pkg;

    localparam int TL_AIW          = 8;
    localparam int TL_HOST_AIW_MAX = 16;

endpackage

// File: rtl/tlul_remap_alloc.sv
// Lowest-free priority encoder for the source remapper's ID pool.
// Ports:
//   busy_i     : one bit per narrow ID, 1 = in use.
//   free_idx_o : lowest index whose busy bit is 0 (0 when none are free).
//   any_free_o : at least one ID is free.
module tlul_remap_alloc #(
    parameter int NumIds = 16,
    parameter int IdxW   = (NumIds > 1) ? $clog2(NumIds) : 1
) (
    input  logic [NumIds-1:0] busy_i,
    output logic [IdxW-1:0]   free_idx_o,
    output logic              any_free_o
);

    // Scan from the top down so the last hit, i.e. the lowest free
    // index, is the one that sticks.
    always_comb begin
        free_idx_o = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (!busy_i[i]) begin
                free_idx_o = IdxW'(i);
            end
        end
    end

    assign any_free_o = ~&busy_i;

endmodule

// File: rtl/tlul_source_remap.sv
// TL-UL source-ID remapper. Narrows a wide host a_source onto a pool of
// NumIds device-side IDs. It remembers the host source per ID and
// restores it on the D response. Only valid/ready and the source fields
// pass through here.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset.
//   host_a_* / dev_a_*            : A channel, host -> device.
//   dev_d_* / host_d_*            : D channel, device -> host.
//   full_o                        : no free ID.
//   err_o                         : sticky; D for an idle or out-of-range ID.
//   outstanding_o, hwm_o          : IDs in use and their high-water mark.
// Build option: define CEP_TLUL_REMAP_STATS_EN to build the outstanding and
// high-water-mark counters. Without it both outputs are tied to 0.
module tlul_source_remap
    import top_pkg::*;
#(
    parameter int HostSrcW = 8,
    parameter int NumIds   = 16,
    parameter int CntW     = $clog2(NumIds + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                host_a_valid_i,
    output logic                host_a_ready_o,
    input  logic [HostSrcW-1:0] host_a_source_i,
    output logic                dev_a_valid_o,
    input  logic                dev_a_ready_i,
    output logic [TL_AIW-1:0]   dev_a_source_o,
    input  logic                dev_d_valid_i,
    output logic                dev_d_ready_o,
    input  logic [TL_AIW-1:0]   dev_d_source_i,
    output logic                host_d_valid_o,
    input  logic                host_d_ready_i,
    output logic [HostSrcW-1:0] host_d_source_o,
    output logic                full_o,
    output logic                err_o,
    output logic [CntW-1:0]     outstanding_o,
    output logic [CntW-1:0]     hwm_o
);

    localparam int IdxW = (NumIds > 1) ? $clog2(NumIds) : 1;
    localparam logic [TL_AIW:0] NumIdsW = (TL_AIW + 1)'(NumIds);

    logic [NumIds-1:0]   busy_q, busy_d;
    logic [HostSrcW-1:0] tbl_q [NumIds];
    logic [HostSrcW-1:0] tbl_d [NumIds];
    logic                err_q, err_d;

    logic [IdxW-1:0] free_idx;
    logic            any_free;
    logic            a_hs, d_hs;
    logic            d_in_range;
    logic [IdxW-1:0] d_idx;
    logic            d_release;

    tlul_remap_alloc #(
        .NumIds (NumIds),
        .IdxW   (IdxW)
    ) u_alloc (
        .busy_i     (busy_q),
        .free_idx_o (free_idx),
        .any_free_o (any_free)
    );

    // A channel: ready depends only on the downstream ready and pool state,
    // never on host_a_valid_i.
    assign dev_a_valid_o  = host_a_valid_i & any_free;
    assign host_a_ready_o = dev_a_ready_i & any_free;
    assign full_o         = ~any_free;

    always_comb begin
        dev_a_source_o = '0;
        dev_a_source_o[IdxW-1:0] = free_idx;
    end

    // D channel passes straight through; the table lookup is the only logic.
    assign host_d_valid_o = dev_d_valid_i;
    assign dev_d_ready_o  = host_d_ready_i;
    assign d_in_range     = {1'b0, dev_d_source_i} < NumIdsW;
    assign d_idx          = dev_d_source_i[IdxW-1:0];
    assign host_d_source_o = d_in_range ? tbl_q[d_idx] : '0;

    assign a_hs      = dev_a_valid_o & dev_a_ready_i;
    assign d_hs      = dev_d_valid_i & host_d_ready_i;
    assign d_release = d_hs & d_in_range & busy_q[d_idx];

    // Allocation always reads the registered busy_q, so an ID released this
    // cycle is not handed out until the next one. The allocated index is
    // free and the released one busy, so the two writes never collide.
    always_comb begin
        busy_d = busy_q;
        tbl_d  = tbl_q;
        err_d  = err_q;
        if (a_hs) begin
            busy_d[free_idx] = 1'b1;
            tbl_d[free_idx]  = host_a_source_i;
        end
        if (d_release) begin
            busy_d[d_idx] = 1'b0;
        end else if (d_hs) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NumIds; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            tbl_q  <= tbl_d;
        end
    end

    assign err_o = err_q;

`ifdef CEP_TLUL_REMAP_STATS_EN
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] hwm_q, hwm_d;

    // An allocate and a release in the same cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (a_hs && !d_release) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!a_hs && d_release) begin
            outstanding_d = outstanding_q - CntW'(1);
        end
        hwm_d = (outstanding_d > hwm_q) ? outstanding_d : hwm_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            hwm_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            hwm_q         <= hwm_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign hwm_o         = hwm_q;
`else
    assign outstanding_o = '0;
    assign hwm_o         = '0;
`endif

endmodule

// File: tb/tb_tlul_source_remap.sv
module tb_tlul_source_remap;
    import top_pkg::*;

`ifdef CEP_TLUL_REMAP_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk;
    logic rst_n;

    // 16-ID instance
    logic                host_a_valid, host_a_ready, dev_a_valid, dev_a_ready;
    logic [7:0]          host_a_source;
    logic [TL_AIW-1:0]   dev_a_source;
    logic                dev_d_valid, dev_d_ready, host_d_valid, host_d_ready;
    logic [TL_AIW-1:0]   dev_d_source;
    logic [7:0]          host_d_source;
    logic                full, err;
    logic [4:0]          outstanding, hwm;

    // 8-ID instance for out-of-range responses
    logic                host_a_valid8, host_a_ready8, dev_a_valid8, dev_a_ready8;
    logic [7:0]          host_a_source8;
    logic [TL_AIW-1:0]   dev_a_source8;
    logic                dev_d_valid8, dev_d_ready8, host_d_valid8, host_d_ready8;
    logic [TL_AIW-1:0]   dev_d_source8;
    logic [7:0]          host_d_source8;
    logic                full8, err8;
    logic [3:0]          outstanding8, hwm8;

    int total = 0;
    int bad   = 0;

    tlul_source_remap #(.HostSrcW(8), .NumIds(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_a_valid_i(host_a_valid), .host_a_ready_o(host_a_ready),
        .host_a_source_i(host_a_source),
        .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready),
        .dev_a_source_o(dev_a_source),
        .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready),
        .dev_d_source_i(dev_d_source),
        .host_d_valid_o(host_d_valid), .host_d_ready_i(host_d_ready),
        .host_d_source_o(host_d_source),
        .full_o(full), .err_o(err),
        .outstanding_o(outstanding), .hwm_o(hwm)
    );

    tlul_source_remap #(.HostSrcW(8), .NumIds(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .host_a_valid_i(host_a_valid8), .host_a_ready_o(host_a_ready8),
        .host_a_source_i(host_a_source8),
        .dev_a_valid_o(dev_a_valid8), .dev_a_ready_i(dev_a_ready8),
        .dev_a_source_o(dev_a_source8),
        .dev_d_valid_i(dev_d_valid8), .dev_d_ready_o(dev_d_ready8),
        .dev_d_source_i(dev_d_source8),
        .host_d_valid_o(host_d_valid8), .host_d_ready_i(host_d_ready8),
        .host_d_source_o(host_d_source8),
        .full_o(full8), .err_o(err8),
        .outstanding_o(outstanding8), .hwm_o(hwm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        host_a_valid = 0; host_a_source = 0; dev_a_ready = 1;
        dev_d_valid = 0; dev_d_source = 0; host_d_ready = 1;
        host_a_valid8 = 0; host_a_source8 = 0; dev_a_ready8 = 1;
        dev_d_valid8 = 0; dev_d_source8 = 0; host_d_ready8 = 1;

        // Outputs while held in reset
        #3;
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_hwm", hwm, 0);
        check("rst_a_ready_hi", host_a_ready, 1);
        check("rst_dev_a_source", dev_a_source, 0);
        dev_a_ready = 0;
        #1;
        check("rst_a_ready_lo", host_a_ready, 0);
        dev_a_ready = 1;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Fill all 16 IDs back to back
        for (int i = 0; i < 16; i++) begin
            host_a_valid  = 1;
            host_a_source = 8'h80 + 8'(i);
            #1;
            check($sformatf("fill_src%0d", i), dev_a_source, i);
            check($sformatf("fill_rdy%0d", i), host_a_ready, 1);
            tick();
        end
        host_a_source = 8'h90;
        #1;
        check("full_flag", full, 1);
        check("full_a_ready", host_a_ready, 0);
        check("full_dev_a_valid", dev_a_valid, 0);
        check("full_outstanding", outstanding, 16 * STATS);
        check("full_hwm", hwm, 16 * STATS);

        // Release ID 5 while full; stalled beat then takes ID 5
        dev_d_valid = 1; dev_d_source = 5;
        #1;
        check("d5_host_src", host_d_source, 8'h85);
        check("d5_host_valid", host_d_valid, 1);
        check("d5_dev_ready", dev_d_ready, 1);
        check("d5_a_still_stalled", host_a_ready, 0);
        tick();
        dev_d_valid = 0;
        #1;
        check("realloc_src", dev_a_source, 5);
        check("realloc_ready", host_a_ready, 1);
        tick();
        host_a_valid = 0;
        #1;
        check("refull", full, 1);

        // Free ID 0 so 15 are busy
        dev_d_valid = 1; dev_d_source = 0;
        #1;
        check("d0_host_src", host_d_source, 8'h80);
        tick();
        dev_d_valid = 0;
        #1;
        check("busy15_outstanding", outstanding, 15 * STATS);
        check("busy15_free_idx", dev_a_source, 0);

        // Same-cycle allocate (gets 0) and release of 3
        host_a_valid = 1; host_a_source = 8'hA0;
        dev_d_valid = 1; dev_d_source = 3;
        #1;
        check("simul_a_src", dev_a_source, 0);
        check("simul_d_src", host_d_source, 8'h83);
        tick();
        host_a_valid = 0; dev_d_valid = 0;
        #1;
        check("simul_next_free", dev_a_source, 3);
        check("simul_not_full", full, 0);
        check("simul_outstanding", outstanding, 15 * STATS);

        // Host stalls D on ID 9 for 4 cycles
        dev_d_valid = 1; dev_d_source = 9; host_d_ready = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("stall%0d_dev_ready", c), dev_d_ready, 0);
            check($sformatf("stall%0d_src", c), host_d_source, 8'h89);
            tick();
        end
        check("stall_outstanding", outstanding, 15 * STATS);
        host_d_ready = 1;
        #1;
        check("stall_release_ready", dev_d_ready, 1);
        tick();
        dev_d_valid = 0;
        #1;
        check("stall_no_err", err, 0);
        check("stall_outstanding_after", outstanding, 14 * STATS);

        // Release 7, then respond on now-idle 7
        dev_d_valid = 1; dev_d_source = 7;
        #1;
        check("d7_host_src", host_d_source, 8'h87);
        tick();
        tick();
        dev_d_valid = 0;
        #1;
        check("idle7_err", err, 1);
        check("idle7_outstanding", outstanding, 13 * STATS);
        check("idle7_free_idx", dev_a_source, 3);
        repeat (3) tick();
        check("err_sticky", err, 1);

        // Out-of-range ID on the 8-ID instance
        dev_d_valid8 = 1; dev_d_source8 = 15;
        #1;
        check("oor_host_src", host_d_source8, 0);
        check("oor_err_before", err8, 0);
        tick();
        dev_d_valid8 = 0;
        #1;
        check("oor_err_after", err8, 1);

        // Reset with 6 outstanding
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        check("rst2_err", err, 0);
        check("rst2_hwm", hwm, 0);
        for (int i = 0; i < 6; i++) begin
            host_a_valid  = 1;
            host_a_source = 8'h40 + 8'(i);
            #1;
            check($sformatf("six_src%0d", i), dev_a_source, i);
            tick();
        end
        host_a_valid = 0;
        #1;
        check("six_outstanding", outstanding, 6 * STATS);
        check("six_hwm", hwm, 6 * STATS);
        check("six_free_idx", dev_a_source, 6);
        host_a_valid = 1;
        rst_n = 0;
        #1;
        check("midrst_full", full, 0);
        check("midrst_err", err, 0);
        check("midrst_outstanding", outstanding, 0);
        check("midrst_hwm", hwm, 0);
        check("midrst_dev_a_src", dev_a_source, 0);
        check("midrst_a_ready", host_a_ready, 1);
        tick();
        host_a_valid = 0;
        rst_n = 1;
        tick();
        dev_d_valid = 1; dev_d_source = 2;
        #1;
        check("post_rst_d_src", host_d_source, 0);
        tick();
        dev_d_valid = 0;
        #1;
        check("post_rst_d_err", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
